// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Shared types and constants for the FIFO write-port arbiter.
//           Optional statistics are enabled with macro FIFO_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Occupancy counter width for a given FIFO depth (must reach DEPTH itself)
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W  = lvl_w(8);
    localparam int STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotating-priority picker. Returns the first set
//           request at or after ptr (modulo N) as one-hot and as an index.
//           Part of fifo_wr_arbiter (stats macro FIFO_ARB_STATS_EN unused here).
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Scan requests starting at ptr and take the first one found
    always_comb begin
        logic w_found;
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!w_found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin burst arbiter sharing one FIFO write port among
//           N_REQ producers; gates pops and tracks occupancy (full/empty/level).
//           Define FIFO_ARB_STATS_EN to add per-producer accepted-word counters
//           on output grant_cnt.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     pop,
    output logic                     f_w_en,
    output logic [DW-1:0]            f_din,
    output logic                     f_r_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
`ifdef FIFO_ARB_STATS_EN
    ,output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int c_iw = $clog2(N_REQ);
    localparam int c_lw = lvl_w(DEPTH);
    localparam int c_bw = 4;
    localparam logic [c_bw-1:0] c_burst_last = c_bw'(MAX_BURST - 1);
    localparam logic [c_iw-1:0] c_last_idx   = c_iw'(N_REQ - 1);
    localparam logic [c_lw-1:0] c_depth      = c_lw'(DEPTH);

    state_t             r_state;
    logic [c_iw-1:0]    r_owner;
    logic [c_iw-1:0]    r_rr_ptr;
    logic [c_bw-1:0]    r_burst_cnt;
    logic [c_lw-1:0]    r_level;

    logic [N_REQ-1:0]   w_pick_grant;
    logic [c_iw-1:0]    w_pick_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_wen;
    logic               w_ren;
    logic               w_last;
    logic               w_exit;
    logic [c_iw-1:0]    w_next_ptr;

    rr_pick #(
        .N  (N_REQ),
        .IW (c_iw)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx)
    );

    assign w_full  = (r_level == c_depth);
    assign w_empty = (r_level == '0);
    assign full    = w_full;
    assign empty   = w_empty;
    assign level   = r_level;

    // Only the owner may be ready, and never while the FIFO is full
    always_comb begin
        req_ready = '0;
        if (r_state == GRANT) begin
            req_ready[r_owner] = !w_full;
        end
    end

    assign w_wen  = (r_state == GRANT) && req_valid[r_owner] && !w_full;
    assign w_ren  = pop && !w_empty;
    assign f_w_en = w_wen;
    assign f_r_en = w_ren;
    assign f_din  = w_wen ? req_data[int'(r_owner)*DW +: DW] : '0;

    // Burst ends on owner drop, final permitted write, or a full FIFO
    assign w_last     = w_wen && (r_burst_cnt == c_burst_last);
    assign w_exit     = !req_valid[r_owner] || w_last || w_full;
    assign w_next_ptr = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

    // Arbitration FSM: one idle cycle to pick, then stream until the burst ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_burst_cnt <= '0;
                    if (|w_pick_grant && !w_full) begin
                        r_owner <= w_pick_idx;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_wen) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                    if (w_exit) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Occupancy: simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
        end else begin
            case ({w_wen, w_ren})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stats
        logic [STAT_W-1:0] r_cnt;

        // Saturating count of words accepted from this producer
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt <= '0;
            end else if (w_wen && (r_owner == c_iw'(i)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[i*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Scoreboard bench for fifo_wr_arbiter. Define FIFO_ARB_STATS_EN to
//           also exercise the grant_cnt statistics output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*DW-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  pop;
    logic                  f_w_en;
    logic [DW-1:0]         f_din;
    logic                  f_r_en;
    logic                  full;
    logic                  empty;
    logic [3:0]            level;
`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*16-1:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pop       (pop),
        .f_w_en    (f_w_en),
        .f_din     (f_din),
        .f_r_en    (f_r_en),
        .full      (full),
        .empty     (empty),
        .level     (level)
`ifdef FIFO_ARB_STATS_EN
        ,.grant_cnt(grant_cnt)
`endif
    );

    logic [DW-1:0] pq [N_REQ][$];
    logic [DW-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int lvl_m    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present the head of each producer queue
    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = pq[i][0];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
            end
        end
    endtask

    // One clock: accepted words leave their producer queue after the edge
    task automatic tick(input logic p);
        logic [N_REQ-1:0] acc;
        pop = p;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        drive();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1'b0);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) pq[i].delete();
        exp_q.delete();
        drive();
        tick(1'b0);
        tick(1'b0);
        rst = 1'b1;
    endtask

    // Monitor: occupancy model and in-order write scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                lvl_m = 0;
            end else begin
                chk("level", level, lvl_m);
                chk("full", full, lvl_m == DEPTH);
                chk("empty", empty, lvl_m == 0);
                chk("f_r_en", f_r_en, pop && (lvl_m != 0));
                chk("ready_onehot", $onehot0(req_ready), 1);
                chk("wen_vs_handshake", f_w_en, |(req_valid & req_ready));
                if (lvl_m == DEPTH) chk("ready_when_full", req_ready, 0);
                if (f_w_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h required=none", f_din);
                    end else begin
                        chk("f_din", f_din, exp_q.pop_front());
                    end
                end else begin
                    chk("f_din_idle", f_din, 0);
                end
                lvl_m = lvl_m + int'(f_w_en) - int'(f_r_en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_data  = '1;
        pop       = 1'b1;
        @(negedge clk);
        chk("reset_level", level, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_wen", f_w_en, 0);
        chk("reset_ren", f_r_en, 0);
        chk("reset_din", f_din, 0);
        @(posedge clk);
        #1;
        pop = 1'b0;
        drive();
        rst = 1'b1;
        tick(1'b0);

        // Pop while empty is dropped
        pop = 1'b1;
        #1;
        chk("pop_empty_ren", f_r_en, 0);
        tick(1'b1);
        tick(1'b0);
        chk("pop_empty_level", level, 0);
        chk("pop_empty_flag", empty, 1);

        // Single producer stream: one arbitration cycle then three writes
        pq[0].push_back(8'hA1); pq[0].push_back(8'hA2); pq[0].push_back(8'hA3);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        drive();
        #1;
        chk("arb_cycle_no_write", f_w_en, 0);
        tick(1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stream_wen", f_w_en, 1);
            tick(1'b0);
        end
        #1;
        chk("stream_end_wen", f_w_en, 0);
        chk("stream_level", level, 3);
        tick(1'b0);

        // rr_ptr now 1: producer 1 wins over producer 0
        pq[0].push_back(8'hB0);
        pq[1].push_back(8'hB1);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB0);
        drive();
        wait_drain("drain_rr", 12);
        tick(1'b0);
        chk("rr_level", level, 5);

        // Drain with pops
        for (int k = 0; k < 6; k++) tick(1'b1);
        tick(1'b0);
        chk("drained_empty", empty, 1);

        // Fill with all producers busy: P0 x4, P1 x4, then full
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 6; k++) pq[i].push_back(8'(i*16 + k));
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(i*16 + k));
        drive();
        wait_drain("drain_fill", 30);
        tick(1'b0); tick(1'b0); tick(1'b0);
        chk("fill_full", full, 1);
        chk("fill_level", level, 8);
        chk("fill_ready", req_ready, 0);

        // Pop at full: push blocked this cycle, producer 2 writes afterwards
        pop = 1'b1;
        #1;
        chk("full_pop_ren", f_r_en, 1);
        chk("full_pop_wen", f_w_en, 0);
        exp_q.push_back(8'h20);
        tick(1'b1);
        chk("full_pop_level", level, 7);
        pop = 1'b0;
        wait_drain("drain_p2", 10);
        chk("refill_level", level, 8);

        // Single-pop drains rotate the grant 3, 0, 1
        exp_q.push_back(8'h30); tick(1'b1); wait_drain("drain_p3", 10);
        exp_q.push_back(8'h04); tick(1'b1); wait_drain("drain_p0", 10);
        exp_q.push_back(8'h14); tick(1'b1); wait_drain("drain_p1", 10);

        // Reset in the middle of a burst
        do_reset();
        pq[2].push_back(8'h2A);
        exp_q.push_back(8'h2A);
        drive();
        wait_drain("drain_pre", 10);
        tick(1'b0);
        for (int k = 0; k < 4; k++) pq[1].push_back(8'hD0 + 8'(k));
        exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
        drive();
        wait_drain("drain_two", 10);
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 0);
        chk("midrst_level", level, 0);
        chk("midrst_wen", f_w_en, 0);
        pq[0].push_back(8'hE0);
        pq[3].push_back(8'hF0);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hD2);
        exp_q.push_back(8'hD3); exp_q.push_back(8'hF0);
        drive();
        tick(1'b0); tick(1'b0);
        rst = 1'b1;
        wait_drain("drain_restart", 20);
        tick(1'b0);
        chk("restart_level", level, 4);

`ifdef FIFO_ARB_STATS_EN
        // Producer 1 writes five words
        do_reset();
        chk("stats_reset", grant_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            pq[1].push_back(8'h50 + 8'(k));
            exp_q.push_back(8'h50 + 8'(k));
        end
        drive();
        wait_drain("drain_stats", 20);
        tick(1'b0);
        chk("stats_p1", grant_cnt[31:16], 5);
        chk("stats_others", {grant_cnt[63:32], grant_cnt[15:0]}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
